// File: rtl/bcedn_pixel_feeder_if.sv
// Host pixel stream and adapter handshake bundle for the B-CEDN pixel feeder.
interface bcedn_pixel_feeder_if #(
   parameter int DATA_IN_FP_WIDTH = 8
);
   logic                        s_valid;
   logic [DATA_IN_FP_WIDTH-1:0] s_data;
   logic                        s_last;
   logic                        s_ready;
   logic                        tg_next;
   logic                        start;
   logic                        in_en;
   logic [DATA_IN_FP_WIDTH-1:0] data_out;
   logic                        frame_err;
   logic                        busy;

   modport master (
      output s_valid, s_data, s_last, tg_next,
      input  s_ready, start, in_en, data_out, frame_err, busy
   );

   modport slave (
      input  s_valid, s_data, s_last, tg_next,
      output s_ready, start, in_en, data_out, frame_err, busy
   );
endinterface

// File: rtl/bcedn_pixel_feeder.sv
// Buffers host frames and replays them in raster order to the B-CEDN adapter.
// Define BCEDN_FEEDER_PINGPONG_EN for two ping-pong banks; default is one bank.
module bcedn_pixel_feeder #(
   parameter int H                = 32,
   parameter int W                = 128,
   parameter int DATA_IN_FP_WIDTH = 8,
   parameter int ROW_GAP          = 0
) (
   input logic                 clk,
   input logic                 rst,
   bcedn_pixel_feeder_if.slave bus
);
   localparam int N  = H * W;
   localparam int AW = (N > 1) ? $clog2(N) : 1;
   localparam int CW = (W > 1) ? $clog2(W) : 1;
   localparam int GW = (ROW_GAP > 0) ? $clog2(ROW_GAP + 1) : 1;
   localparam logic [AW-1:0] LAST_ADDR = AW'(N - 1);
   localparam logic [CW-1:0] COL_LAST  = CW'(W - 1);
   localparam logic [GW-1:0] GAP_LAST  = GW'((ROW_GAP > 0) ? ROW_GAP - 1 : 0);

`ifdef BCEDN_FEEDER_PINGPONG_EN
   localparam int NB = 2;
   logic wr_bank;
   logic rd_bank;
   logic [DATA_IN_FP_WIDTH-1:0] mem1 [N];
`else
   localparam int NB = 1;
   localparam logic wr_bank = 1'b0;
   localparam logic rd_bank = 1'b0;
`endif

   typedef enum logic [1:0] {IDLE, START, STREAM, GAP} state_t;

   state_t                      state;
   state_t                      state_n;
   logic [NB-1:0]               full;
   logic [AW-1:0]               wr_cnt;
   logic [AW-1:0]               rd_addr;
   logic [CW-1:0]               col;
   logic [GW-1:0]               gap_cnt;
   logic                        credit;
   logic                        s_ready_i;
   logic                        accept;
   logic                        issue;
   logic                        rel_bank;
   logic                        frame_err_r;
   logic                        vld_p1;
   logic [DATA_IN_FP_WIDTH-1:0] rd_data_p1;
   logic [DATA_IN_FP_WIDTH-1:0] mem0 [N];

`ifdef BCEDN_FEEDER_PINGPONG_EN
   assign s_ready_i = !full[wr_bank];
`else
   assign s_ready_i = !full[0] && (state == IDLE);
`endif
   assign accept = bus.s_valid && s_ready_i;

   always_comb begin
      state_n  = state;
      issue    = 1'b0;
      rel_bank = 1'b0;
      case (state)
         IDLE: if (full[rd_bank] && credit) state_n = START;
         START, STREAM: begin
            issue = 1'b1;
            if (rd_addr == LAST_ADDR) begin
               rel_bank = 1'b1;
               state_n  = IDLE;
            end else if (ROW_GAP > 0 && col == COL_LAST) begin
               state_n = GAP;
            end else begin
               state_n = STREAM;
            end
         end
         GAP: if (gap_cnt == GAP_LAST) state_n = STREAM;
         default: state_n = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         full        <= '0;
         wr_cnt      <= '0;
         rd_addr     <= '0;
         col         <= '0;
         gap_cnt     <= '0;
         credit      <= 1'b1;
         frame_err_r <= 1'b0;
         vld_p1      <= 1'b0;
`ifdef BCEDN_FEEDER_PINGPONG_EN
         wr_bank     <= 1'b0;
         rd_bank     <= 1'b0;
`endif
      end else begin
         state       <= state_n;
         vld_p1      <= issue;
         frame_err_r <= 1'b0;
         // tg_next wins over start so a simultaneous pair keeps the credit
         if (bus.tg_next) credit <= 1'b1;
         else if (state == START) credit <= 1'b0;
         if (accept) begin
            if (wr_cnt == LAST_ADDR) begin
               wr_cnt        <= '0;
               full[wr_bank] <= 1'b1;
               frame_err_r   <= !bus.s_last;
`ifdef BCEDN_FEEDER_PINGPONG_EN
               wr_bank       <= !wr_bank;
`endif
            end else if (bus.s_last) begin
               wr_cnt      <= '0;
               frame_err_r <= 1'b1;
            end else begin
               wr_cnt <= wr_cnt + 1'b1;
            end
         end
         if (issue) begin
            rd_addr <= rel_bank ? '0 : rd_addr + 1'b1;
            col     <= (col == COL_LAST) ? '0 : col + 1'b1;
         end
         if (state == GAP) gap_cnt <= (gap_cnt == GAP_LAST) ? '0 : gap_cnt + 1'b1;
         if (rel_bank) begin
            full[rd_bank] <= 1'b0;
`ifdef BCEDN_FEEDER_PINGPONG_EN
            rd_bank       <= !rd_bank;
`endif
         end
      end
   end

   // p0 -> p1: frame RAM write and one-cycle synchronous read
   always_ff @(posedge clk) begin
      if (accept) begin
`ifdef BCEDN_FEEDER_PINGPONG_EN
         if (wr_bank) mem1[wr_cnt] <= bus.s_data;
         else         mem0[wr_cnt] <= bus.s_data;
`else
         mem0[wr_cnt] <= bus.s_data;
`endif
      end
      if (issue) begin
`ifdef BCEDN_FEEDER_PINGPONG_EN
         rd_data_p1 <= rd_bank ? mem1[rd_addr] : mem0[rd_addr];
`else
         rd_data_p1 <= mem0[rd_addr];
`endif
      end
   end

   assign bus.s_ready   = s_ready_i;
   assign bus.start     = (state == START);
   assign bus.in_en     = vld_p1;
   assign bus.data_out  = vld_p1 ? rd_data_p1 : '0;
   assign bus.frame_err = frame_err_r;
   assign bus.busy      = (state != IDLE);
endmodule

// File: tb/tb_bcedn_pixel_feeder.sv
// Directed bench for bcedn_pixel_feeder: H=2, W=4, one instance with ROW_GAP=0, one with ROW_GAP=2.
module tb_bcedn_pixel_feeder;
   localparam int H  = 2;
   localparam int W  = 4;
   localparam int DW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_checks = 0;
   int   n_fail   = 0;

   always #5 clk = ~clk;

   bcedn_pixel_feeder_if #(.DATA_IN_FP_WIDTH(DW)) f0 ();
   bcedn_pixel_feeder_if #(.DATA_IN_FP_WIDTH(DW)) f2 ();

   bcedn_pixel_feeder #(.H(H), .W(W), .DATA_IN_FP_WIDTH(DW), .ROW_GAP(0)) dut0 (
      .clk(clk), .rst(rst), .bus(f0.slave));
   bcedn_pixel_feeder #(.H(H), .W(W), .DATA_IN_FP_WIDTH(DW), .ROW_GAP(2)) dut2 (
      .clk(clk), .rst(rst), .bus(f2.slave));

   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached, got no end of test, want summary");
      $fatal(1);
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs;
      f0.s_valid = 1'b0; f0.s_data = '0; f0.s_last = 1'b0; f0.tg_next = 1'b0;
      f2.s_valid = 1'b0; f2.s_data = '0; f2.s_last = 1'b0; f2.tg_next = 1'b0;
   endtask

   // Drives n beats base..base+n-1 on f0; s_last on beat number last_at (1-based, 0 = never).
   task automatic send0(input int base, input int n, input int last_at);
      for (int i = 0; i < n; i++) begin
         f0.s_valid = 1'b1;
         f0.s_data  = DW'(base + i);
         f0.s_last  = (i + 1 == last_at);
         tick();
      end
      f0.s_valid = 1'b0;
      f0.s_last  = 1'b0;
   endtask

   task automatic pulse_tg0;
      f0.tg_next = 1'b1;
      tick();
      f0.tg_next = 1'b0;
   endtask

   task automatic test_reset;
      rst = 1'b1;
      tick();
      tick();
      n_checks++; if (f0.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_s_ready: got %b want 1", f0.s_ready); end
      n_checks++; if (f0.start !== 1'b0) begin n_fail++; $display("FAIL reset_start: got %b want 0", f0.start); end
      n_checks++; if (f0.in_en !== 1'b0) begin n_fail++; $display("FAIL reset_in_en: got %b want 0", f0.in_en); end
      n_checks++; if (f0.data_out !== 8'd0) begin n_fail++; $display("FAIL reset_data_out: got %0d want 0", f0.data_out); end
      n_checks++; if (f0.frame_err !== 1'b0) begin n_fail++; $display("FAIL reset_frame_err: got %b want 0", f0.frame_err); end
      n_checks++; if (f0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", f0.busy); end
      n_checks++; if (f2.s_ready !== 1'b1) begin n_fail++; $display("FAIL reset_g2_s_ready: got %b want 1", f2.s_ready); end
      n_checks++; if (f2.in_en !== 1'b0) begin n_fail++; $display("FAIL reset_g2_in_en: got %b want 0", f2.in_en); end
      rst = 1'b0;
      tick();
      n_checks++; if (f0.busy !== 1'b0) begin n_fail++; $display("FAIL reset_idle_busy: got %b want 0", f0.busy); end
   endtask

   task automatic test_basic;
      send0(1, 8, 8);
      n_checks++; if (f0.start !== 1'b0) begin n_fail++; $display("FAIL basic_start_early: got %b want 0", f0.start); end
      tick();
      n_checks++; if (f0.start !== 1'b1) begin n_fail++; $display("FAIL basic_start: got %b want 1", f0.start); end
      n_checks++; if (f0.busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_start: got %b want 1", f0.busy); end
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_checks++; if (f0.in_en !== 1'b1) begin n_fail++; $display("FAIL basic_in_en[%0d]: got %b want 1", i, f0.in_en); end
         n_checks++; if (f0.data_out !== DW'(i)) begin n_fail++; $display("FAIL basic_data[%0d]: got %0d want %0d", i, f0.data_out, i); end
         n_checks++; if (f0.busy !== (i < 8)) begin n_fail++; $display("FAIL basic_busy[%0d]: got %b want %b", i, f0.busy, i < 8); end
         n_checks++; if (f0.start !== 1'b0) begin n_fail++; $display("FAIL basic_single_start[%0d]: got %b want 0", i, f0.start); end
      end
      tick();
      n_checks++; if (f0.in_en !== 1'b0) begin n_fail++; $display("FAIL basic_in_en_end: got %b want 0", f0.in_en); end
      n_checks++; if (f0.data_out !== 8'd0) begin n_fail++; $display("FAIL basic_data_end: got %0d want 0", f0.data_out); end
   endtask

   task automatic test_row_gap;
      logic exp_en;
      for (int i = 0; i < 8; i++) begin
         f2.s_valid = 1'b1;
         f2.s_data  = DW'(i + 1);
         f2.s_last  = (i == 7);
         tick();
      end
      f2.s_valid = 1'b0;
      f2.s_last  = 1'b0;
      tick();
      n_checks++; if (f2.start !== 1'b1) begin n_fail++; $display("FAIL gap_start: got %b want 1", f2.start); end
      // Expected: 4 on (t+1..t+4), 2 off, 4 on (t+7..t+10), then off
      for (int k = 1; k <= 11; k++) begin
         tick();
         exp_en = (k <= 4) || (k >= 7 && k <= 10);
         n_checks++; if (f2.in_en !== exp_en) begin n_fail++; $display("FAIL gap_in_en[t+%0d]: got %b want %b", k, f2.in_en, exp_en); end
         if (exp_en) begin
            n_checks++; if (f2.data_out !== DW'((k <= 4) ? k : k - 2)) begin n_fail++; $display("FAIL gap_data[t+%0d]: got %0d want %0d", k, f2.data_out, (k <= 4) ? k : k - 2); end
         end
         n_checks++; if (f2.busy !== (k < 10)) begin n_fail++; $display("FAIL gap_busy[t+%0d]: got %b want %b", k, f2.busy, k < 10); end
      end
   endtask

   task automatic test_frame_err;
      pulse_tg0();
      for (int i = 1; i <= 5; i++) begin
         f0.s_valid = 1'b1;
         f0.s_data  = DW'(100 + i);
         f0.s_last  = (i == 5);
         tick();
         n_checks++; if (f0.frame_err !== (i == 5)) begin n_fail++; $display("FAIL early_last_err[%0d]: got %b want %b", i, f0.frame_err, i == 5); end
      end
      f0.s_valid = 1'b0;
      f0.s_last  = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++; if (f0.start !== 1'b0 || f0.frame_err !== 1'b0) begin n_fail++; $display("FAIL dropped_no_start[%0d]: got start=%b err=%b want 0/0", i, f0.start, f0.frame_err); end
      end
      send0(11, 8, 8);
      n_checks++; if (f0.frame_err !== 1'b0) begin n_fail++; $display("FAIL good_frame_err: got %b want 0", f0.frame_err); end
      tick();
      n_checks++; if (f0.start !== 1'b1) begin n_fail++; $display("FAIL after_drop_start: got %b want 1", f0.start); end
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_checks++; if (f0.in_en !== 1'b1 || f0.data_out !== DW'(10 + i)) begin n_fail++; $display("FAIL after_drop_data[%0d]: got en=%b d=%0d want 1/%0d", i, f0.in_en, f0.data_out, 10 + i); end
      end
      tick();
      pulse_tg0();
      send0(21, 8, 0);
      n_checks++; if (f0.frame_err !== 1'b1) begin n_fail++; $display("FAIL missing_last_err: got %b want 1", f0.frame_err); end
      tick();
      n_checks++; if (f0.start !== 1'b1) begin n_fail++; $display("FAIL missing_last_start: got %b want 1", f0.start); end
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_checks++; if (f0.in_en !== 1'b1 || f0.data_out !== DW'(20 + i)) begin n_fail++; $display("FAIL missing_last_data[%0d]: got en=%b d=%0d want 1/%0d", i, f0.in_en, f0.data_out, 20 + i); end
      end
      tick();
   endtask

   task automatic test_mid_reset;
      pulse_tg0();
      send0(31, 8, 8);
      tick();
      n_checks++; if (f0.start !== 1'b1) begin n_fail++; $display("FAIL mid_rst_start: got %b want 1", f0.start); end
      for (int i = 1; i <= 3; i++) begin
         tick();
         n_checks++; if (f0.data_out !== DW'(30 + i)) begin n_fail++; $display("FAIL mid_rst_pre[%0d]: got %0d want %0d", i, f0.data_out, 30 + i); end
      end
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_checks++; if (f0.in_en !== 1'b0 || f0.data_out !== 8'd0) begin n_fail++; $display("FAIL mid_rst_out: got en=%b d=%0d want 0/0", f0.in_en, f0.data_out); end
      n_checks++; if (f0.busy !== 1'b0 || f0.start !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ctrl: got busy=%b start=%b want 0/0", f0.busy, f0.start); end
      n_checks++; if (f0.s_ready !== 1'b1 || f0.frame_err !== 1'b0) begin n_fail++; $display("FAIL mid_rst_ready: got rdy=%b err=%b want 1/0", f0.s_ready, f0.frame_err); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (f0.in_en !== 1'b0 || f0.busy !== 1'b0) begin n_fail++; $display("FAIL mid_rst_quiet[%0d]: got en=%b busy=%b want 0/0", i, f0.in_en, f0.busy); end
      end
      send0(41, 8, 8);
      tick();
      n_checks++; if (f0.start !== 1'b1) begin n_fail++; $display("FAIL post_rst_start: got %b want 1", f0.start); end
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_checks++; if (f0.in_en !== 1'b1 || f0.data_out !== DW'(40 + i)) begin n_fail++; $display("FAIL post_rst_data[%0d]: got en=%b d=%0d want 1/%0d", i, f0.in_en, f0.data_out, 40 + i); end
      end
      tick();
      n_checks++; if (f0.in_en !== 1'b0) begin n_fail++; $display("FAIL post_rst_end: got %b want 0", f0.in_en); end
   endtask

`ifdef BCEDN_FEEDER_PINGPONG_EN
   task automatic test_pingpong;
      pulse_tg0();
      for (int i = 0; i < 16; i++) begin
         f0.s_valid = 1'b1;
         f0.s_data  = DW'((i < 8) ? 81 + i : 91 + i - 8);
         f0.s_last  = (i == 7 || i == 15);
         n_checks++; if (f0.s_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_beat[%0d]: got %b want 1", i, f0.s_ready); end
         tick();
         n_checks++; if (f0.start !== (i == 8)) begin n_fail++; $display("FAIL pp_start_a[%0d]: got %b want %b", i, f0.start, i == 8); end
         if (i >= 9) begin
            n_checks++; if (f0.in_en !== 1'b1 || f0.data_out !== DW'(81 + i - 9)) begin n_fail++; $display("FAIL pp_data_a[%0d]: got en=%b d=%0d want 1/%0d", i, f0.in_en, f0.data_out, 81 + i - 9); end
         end
      end
      f0.s_valid = 1'b0;
      f0.s_last  = 1'b0;
      for (int j = 1; j <= 10; j++) begin
         tick();
         n_checks++; if (f0.start !== 1'b0) begin n_fail++; $display("FAIL pp_b_held[%0d]: got %b want 0", j, f0.start); end
         n_checks++; if (f0.s_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_after_a[%0d]: got %b want 1", j, f0.s_ready); end
         if (j == 1) begin
            n_checks++; if (f0.data_out !== 8'd88) begin n_fail++; $display("FAIL pp_data_a_last: got %0d want 88", f0.data_out); end
         end
      end
      send0(101, 8, 8);
      n_checks++; if (f0.s_ready !== 1'b0) begin n_fail++; $display("FAIL pp_both_full_ready: got %b want 0", f0.s_ready); end
      pulse_tg0();
      n_checks++; if (f0.start !== 1'b0) begin n_fail++; $display("FAIL pp_b_start_early: got %b want 0", f0.start); end
      tick();
      n_checks++; if (f0.start !== 1'b1) begin n_fail++; $display("FAIL pp_b_start: got %b want 1", f0.start); end
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_checks++; if (f0.in_en !== 1'b1 || f0.data_out !== DW'(90 + i)) begin n_fail++; $display("FAIL pp_data_b[%0d]: got en=%b d=%0d want 1/%0d", i, f0.in_en, f0.data_out, 90 + i); end
      end
      n_checks++; if (f0.s_ready !== 1'b1) begin n_fail++; $display("FAIL pp_ready_after_b: got %b want 1", f0.s_ready); end
      for (int i = 0; i < 4; i++) begin
         tick();
         n_checks++; if (f0.start !== 1'b0) begin n_fail++; $display("FAIL pp_c_held[%0d]: got %b want 0", i, f0.start); end
      end
   endtask
`else
   task automatic test_single_bank;
      send0(51, 8, 8);
      n_checks++; if (f0.s_ready !== 1'b0) begin n_fail++; $display("FAIL sb_ready_full: got %b want 0", f0.s_ready); end
      for (int i = 0; i < 3; i++) begin
         tick();
         n_checks++; if (f0.start !== 1'b0 || f0.s_ready !== 1'b0) begin n_fail++; $display("FAIL sb_no_credit[%0d]: got start=%b rdy=%b want 0/0", i, f0.start, f0.s_ready); end
      end
      pulse_tg0();
      n_checks++; if (f0.start !== 1'b0) begin n_fail++; $display("FAIL sb_start_early: got %b want 0", f0.start); end
      tick();
      n_checks++; if (f0.start !== 1'b1 || f0.s_ready !== 1'b0) begin n_fail++; $display("FAIL sb_start: got start=%b rdy=%b want 1/0", f0.start, f0.s_ready); end
      // Two tg_next pulses land while streaming
      for (int i = 1; i <= 9; i++) begin
         f0.tg_next = (i == 2 || i == 4);
         tick();
         f0.tg_next = 1'b0;
         n_checks++; if (f0.s_ready !== (i >= 8)) begin n_fail++; $display("FAIL sb_ready_stream[t+%0d]: got %b want %b", i, f0.s_ready, i >= 8); end
         n_checks++; if (f0.in_en !== (i <= 8)) begin n_fail++; $display("FAIL sb_in_en[t+%0d]: got %b want %b", i, f0.in_en, i <= 8); end
         if (i <= 8) begin
            n_checks++; if (f0.data_out !== DW'(50 + i)) begin n_fail++; $display("FAIL sb_data[t+%0d]: got %0d want %0d", i, f0.data_out, 50 + i); end
         end
      end
      send0(61, 8, 8);
      tick();
      n_checks++; if (f0.start !== 1'b1) begin n_fail++; $display("FAIL sb_credit_start: got %b want 1", f0.start); end
      for (int i = 1; i <= 8; i++) begin
         tick();
         n_checks++; if (f0.data_out !== DW'(60 + i)) begin n_fail++; $display("FAIL sb_data2[%0d]: got %0d want %0d", i, f0.data_out, 60 + i); end
      end
      tick();
      send0(71, 8, 8);
      for (int i = 0; i < 6; i++) begin
         tick();
         n_checks++; if (f0.start !== 1'b0) begin n_fail++; $display("FAIL sb_one_credit[%0d]: got %b want 0", i, f0.start); end
      end
   endtask
`endif

   initial begin
      idle_inputs();
      test_reset();
      test_basic();
      test_row_gap();
      test_frame_err();
      test_mid_reset();
`ifdef BCEDN_FEEDER_PINGPONG_EN
      test_pingpong();
`else
      test_single_bank();
`endif
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bcedn_pixel_feeder.md
# bcedn_pixel_feeder

Upstream stage of the full-precision adapter in the B-CEDN pipeline. It accepts raw fixed-point pixels from a host stream and buffers one H×W frame per bank. When a full frame is buffered and the adapter has signalled readiness, it issues a `start` pulse and replays the frame in raster order on `in_en`/`data_out`, with an optional idle gap between rows. Its outputs connect directly to the adapter's `start`, `in_en` and `data_in`; the adapter's `tg_next` comes back as the readiness credit.

## Interface
- `H`, 32, frame height (rows)
- `W`, 128, frame width (pixels per row)
- `DATA_IN_FP_WIDTH`, 8, pixel width in bits
- `ROW_GAP`, 0, idle cycles inserted after each streamed row except the last

- `clk`  in  1  clock; all logic is on the rising edge
- `rst`  in  1  synchronous, active-high reset
- `s_valid`  in  1  host pixel valid
- `s_data`  in  DATA_IN_FP_WIDTH  host pixel
- `s_last`  in  1  host end-of-frame marker
- `s_ready`  out  1  feeder accepts a pixel this cycle
- `tg_next`  in  1  single-cycle pulse from the adapter: it can take a new frame
- `start`  out  1  single-cycle frame-start pulse to the adapter
- `in_en`  out  1  `data_out` valid for the adapter
- `data_out`  out  DATA_IN_FP_WIDTH  streamed pixel
- `frame_err`  out  1  single-cycle pulse on an `s_last` protocol violation
- `busy`  out  1  high while the read FSM is not in IDLE

## Operation
- Storage: two banks of H·W × DATA_IN_FP_WIDTH, each with a `full` flag. The write bank and the read bank are selected independently.
- Write side:
  - A beat is accepted when `s_valid && s_ready`. `s_ready` = !full[wr_bank].
  - `wr_cnt` runs 0..H·W-1. On accepting beat H·W-1: set full[wr_bank], toggle `wr_bank`, clear `wr_cnt`.
  - `s_last` on beat H·W-1: normal end of frame.
  - `s_last` on an earlier beat: frame dropped. `wr_cnt` goes to 0, the bank is not marked full, and `frame_err` pulses.
  - Beat H·W-1 without `s_last`: the frame is closed as normal and `frame_err` pulses.
- Credit:
  - One-bit `credit`, set to 1 by reset.
  - Set by `tg_next`; cleared when `start` issues.
  - A `tg_next` arriving while credit is already 1 is absorbed (saturating).
  - `tg_next` and a `start` in the same cycle leave credit at 1.
- Read FSM: IDLE → START → STREAM ↔ GAP → IDLE.
  - IDLE: leave when `full[rd_bank] && credit`.
  - START: `start`=1 for one cycle; issue the read of address 0.
  - STREAM: issue one read per cycle.
    - After the last pixel of a row, go to GAP if `ROW_GAP`>0 and the row is not the last.
    - After pixel H·W-1, clear full[rd_bank], toggle `rd_bank`, and return to IDLE.
  - GAP: hold for `ROW_GAP` cycles with no reads, then return to STREAM.
- Output path:
  - Synchronous RAM read with one cycle of latency.
  - `in_en` is the read-issue strobe delayed by one cycle, aligned with `data_out`.
  - Exactly H·W `in_en` cycles per `start`.
- Bank release and a write to the other bank in the same cycle are legal. The released bank becomes writable on the next cycle.
- Mid-operation `rst`:
  - Both banks are emptied; counters, bank pointers and FSM are cleared; credit returns to 1.
  - Any partially streamed or partially written frame is discarded.
- Counter widths are `$clog2(H*W)` for `wr_cnt`/read address, `$clog2(W)` for the column counter, and `$clog2(ROW_GAP+1)` for the gap counter.

## Timing
- Reset values: `s_ready`=1, `start`=0, `in_en`=0, `data_out`=0, `frame_err`=0, `busy`=0.
- If `start` is high at cycle t, the first `in_en` is at t+1.
- With `ROW_GAP`=0, `in_en` stays high continuously for H·W cycles, t+1..t+H·W.
- With `ROW_GAP`=G, each row boundary adds G cycles with `in_en`=0. The last `in_en` is at t+H·W+(H-1)·G.
- `busy` falls the cycle after the final read issue.
- A new `start` needs both a full bank and a credit. The earliest back-to-back `start` is one cycle after IDLE is re-entered.
- Latency from the last host beat of a frame to `start` is 2 cycles when IDLE and credit=1: full is registered, then START.

## Configuration
- Macro: `BCEDN_FEEDER_PINGPONG_EN`.
- Defined: two banks as described. The host can load frame N+1 while frame N streams.
- Undefined: one bank only; `wr_bank`/`rd_bank` are fixed at 0.
  - `s_ready` = !full[0] && FSM in IDLE.
  - Loading and streaming are mutually exclusive.
  - Sustained throughput is one frame per 2·H·W + overhead cycles.

## Test plan
- H=2, W=4, G=0, credit=1 after reset; host sends pixels 1..8 with `s_last` on 8 → `start` 2 cycles after the last beat; `in_en` high for 8 consecutive cycles; `data_out` = 1..8.
- Same setup, G=2 → `in_en` pattern 4 on, 2 off, 4 on; last `in_en` at t+10.
- `BCEDN_FEEDER_PINGPONG_EN` defined; send frames A and B back to back, no `tg_next` → A streams; B is held (no second `start`); `s_ready` stays high until a third frame fills bank A; a `tg_next` pulse → `start` for B 1 cycle later.
- `s_last` on beat 5 of 8 → `frame_err` pulse; no `start`; the next full 8-beat frame streams normally. Beat 8 with no `s_last` → `frame_err` pulse and the frame still streams.
- Assert `rst` for 1 cycle during STREAM at pixel 3 → next cycle all outputs at reset values, `s_ready`=1; a new frame streams correctly with no leftover `in_en`.
- PINGPONG undefined → `s_ready`=0 from frame full until the cycle after the last read issue; two `tg_next` pulses while streaming yield only one credit.
